// File: rtl/uart_msg_pkg.sv
// Shared types and constants for the UART message packer: FSM encoding,
// ASCII code points and word geometry.
package uart_msg_pkg;

    localparam int unsigned NUM_CHARS_DEFAULT = 8;
    localparam int unsigned CHAR_W            = 8;
    localparam int unsigned NIB_W             = 4;
    localparam int unsigned VAL_W             = 32;
    localparam int unsigned WORD_W            = NUM_CHARS_DEFAULT * CHAR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_LOAD = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    localparam logic [CHAR_W-1:0] ASCII_0  = 8'h30;
    localparam logic [CHAR_W-1:0] ASCII_A  = 8'h41;
    localparam logic [CHAR_W-1:0] ASCII_CR = 8'h0D;
    localparam logic [CHAR_W-1:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_msg_packer_if.sv
// Request/result bundle between a message source and the packer.
// The packer sits on the slave side and drives the UART-facing outputs.
interface uart_msg_packer_if;

    logic                               send_req;
    logic [uart_msg_pkg::VAL_W-1:0]     value_in;
    logic [uart_msg_pkg::WORD_W-1:0]    write_data;
    logic                               read_uart;
    logic                               busy;
    logic                               done;

    modport master (
        output send_req,
        output value_in,
        input  write_data,
        input  read_uart,
        input  busy,
        input  done
    );

    modport slave (
        input  send_req,
        input  value_in,
        output write_data,
        output read_uart,
        output busy,
        output done
    );

endinterface

// File: rtl/hex_to_ascii.sv
// Combinational nibble to uppercase ASCII hex digit ('0'-'9', 'A'-'F').
module hex_to_ascii
    import uart_msg_pkg::*;
(
    input  logic [NIB_W-1:0]  i_nibble,
    output logic [CHAR_W-1:0] o_ascii_c
);

    always_comb begin
        o_ascii_c = ASCII_0;
        if (i_nibble < 4'd10) begin
            o_ascii_c = ASCII_0 + CHAR_W'(i_nibble);
        end else begin
            o_ascii_c = ASCII_A + CHAR_W'(i_nibble - 4'd10);
        end
    end

endmodule

// File: rtl/uart_msg_packer.sv
// Packs a 32-bit value into an 8-char ASCII hex word, pulses read_uart to load
// the UART Tx FIFO, then stays busy for a drain gap. Optional UART_MSG_PACKER_CRLF_EN
// replaces the two top hex digits with a trailing CR/LF.
module uart_msg_packer
    import uart_msg_pkg::*;
#(
    parameter int unsigned NUM_CHARS  = NUM_CHARS_DEFAULT,
    parameter int unsigned GAP_CYCLES = 833280,
    parameter int unsigned GAP_BITS   = 20
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    uart_msg_packer_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(NUM_CHARS);
    localparam logic [GAP_BITS-1:0] GAP_LOAD  = GAP_BITS'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(NUM_CHARS - 1);

`ifdef UART_MSG_PACKER_CRLF_EN
    // Six hex digits taken from value bits [23:0], then CR, LF.
    localparam logic [4:0]       TOP_NIB_SHIFT = 5'd20;
    localparam logic [CNT_W-1:0] CNT_CR        = CNT_W'(NUM_CHARS - 2);
`else
    localparam logic [4:0]       TOP_NIB_SHIFT = 5'd28;
`endif

    state_e              r_state;
    state_e              w_next_state;
    logic                w_accept;

    logic                r_req_q;
    logic [VAL_W-1:0]    r_val;
    logic [CNT_W-1:0]    r_char_cnt;
    logic [GAP_BITS-1:0] r_gap;
    logic [WORD_W-1:0]   r_write_data;
    logic                r_read_uart;
    logic                r_busy;
    logic                r_done;

    logic [4:0]          w_shift;
    logic [NIB_W-1:0]    w_nibble;
    logic [CHAR_W-1:0]   w_hex_char;
    logic [CHAR_W-1:0]   w_char;

    // Rising edge of the request, only honoured while idle.
    assign w_accept = (r_state == ST_IDLE) && bus.send_req && !r_req_q;

    // FSM state register.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)                w_next_state = ST_PACK;
            ST_PACK: if (r_char_cnt == CNT_LAST)  w_next_state = ST_LOAD;
            ST_LOAD:                              w_next_state = ST_HOLD;
            ST_HOLD: if (r_gap == '0)             w_next_state = ST_IDLE;
            default:                              w_next_state = ST_IDLE;
        endcase
    end

    // Character 0 is the most significant nibble and lands in byte 0.
    assign w_shift  = TOP_NIB_SHIFT - {r_char_cnt, 2'b00};
    assign w_nibble = NIB_W'(r_val >> w_shift);

    hex_to_ascii u_hex_to_ascii (
        .i_nibble  (w_nibble),
        .o_ascii_c (w_hex_char)
    );

    always_comb begin
        w_char = w_hex_char;
`ifdef UART_MSG_PACKER_CRLF_EN
        if (r_char_cnt == CNT_R_CR_SEL(CNT_CR)) begin
            w_char = ASCII_CR;
        end else if (r_char_cnt == CNT_LAST) begin
            w_char = ASCII_LF;
        end
`endif
    end

`ifdef UART_MSG_PACKER_CRLF_EN
    function automatic logic [CNT_W-1:0] CNT_R_CR_SEL(input logic [CNT_W-1:0] c);
        return c;
    endfunction
`endif

    // Datapath, counters and registered outputs.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_req_q      <= 1'b1;
            r_val        <= '0;
            r_char_cnt   <= '0;
            r_gap        <= '0;
            r_write_data <= '0;
            r_read_uart  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_req_q     <= bus.send_req;
            r_read_uart <= (w_next_state == ST_LOAD);
            r_busy      <= (w_next_state != ST_IDLE);
            r_done      <= (r_state == ST_HOLD) && (w_next_state == ST_IDLE);

            if (w_accept) begin
                r_val      <= bus.value_in;
                r_char_cnt <= '0;
            end

            if (r_state == ST_PACK) begin
                r_write_data[{r_char_cnt, 3'b000} +: CHAR_W] <= w_char;
                r_char_cnt <= r_char_cnt + 1'b1;
            end

            // Gap counter is armed during LOAD so HOLD lasts exactly GAP_CYCLES.
            if (r_state == ST_LOAD) begin
                r_gap <= GAP_LOAD;
            end else if ((r_state == ST_HOLD) && (r_gap != '0)) begin
                r_gap <= r_gap - 1'b1;
            end
        end
    end

    assign bus.write_data = r_write_data;
    assign bus.read_uart  = r_read_uart;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

    // Parameter sanity; a zero gap would wrap the counter into a huge hold.
    always @(posedge clk_100MHz) begin
        if (!reset) begin
            assert (GAP_CYCLES != 0)
                else $error("uart_msg_packer: GAP_CYCLES must be nonzero");
            assert (64'(GAP_CYCLES) < (64'd1 << GAP_BITS))
                else $error("uart_msg_packer: GAP_BITS too narrow for GAP_CYCLES");
            assert (NUM_CHARS == NUM_CHARS_DEFAULT)
                else $error("uart_msg_packer: NUM_CHARS must be 8 for a 64-bit word");
        end
    end

endmodule

// File: tb/tb_uart_msg_packer.sv
// Self-checking bench for uart_msg_packer: two instances (gap 20 and gap 1)
// checked against a string-level model of the hex message.
module tb_uart_msg_packer;

    localparam int GAP_A = 20;
    localparam int GAP_B = 1;
    localparam int NC    = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    uart_msg_packer_if bus_a ();
    uart_msg_packer_if bus_b ();

    uart_msg_packer #(.NUM_CHARS(NC), .GAP_CYCLES(GAP_A), .GAP_BITS(20)) dut_a (
        .clk_100MHz (clk),
        .reset      (reset),
        .bus        (bus_a)
    );

    uart_msg_packer #(.NUM_CHARS(NC), .GAP_CYCLES(GAP_B), .GAP_BITS(20)) dut_b (
        .clk_100MHz (clk),
        .reset      (reset),
        .bus        (bus_b)
    );

    // Message as the terminal should see it, char 0 in bits [7:0].
    function automatic logic [63:0] model_word(input logic [31:0] v);
        logic [63:0] w;
        logic [7:0]  c;
        int          nib;
        w = '0;
        for (int i = 0; i < NC; i++) begin
`ifdef UART_MSG_PACKER_CRLF_EN
            nib = int'((v >> (4 * (5 - i))) & 32'hF);
`else
            nib = int'((v >> (4 * (7 - i))) & 32'hF);
`endif
            c = (nib < 10) ? 8'(48 + nib) : 8'(65 + nib - 10);
`ifdef UART_MSG_PACKER_CRLF_EN
            if (i == 6) c = 8'h0D;
            if (i == 7) c = 8'h0A;
`endif
            w = w | (64'(c) << (8 * i));
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic r, input logic [31:0] v);
        if (sel == 0) begin
            bus_a.send_req = r;
            bus_a.value_in = v;
        end else begin
            bus_b.send_req = r;
            bus_b.value_in = v;
        end
    endtask

    task automatic sample(input int sel, output logic ru, output logic bz,
                          output logic dn, output logic [63:0] wd);
        if (sel == 0) begin
            ru = bus_a.read_uart; bz = bus_a.busy; dn = bus_a.done; wd = bus_a.write_data;
        end else begin
            ru = bus_b.read_uart; bz = bus_b.busy; dn = bus_b.done; wd = bus_b.write_data;
        end
    endtask

    // One message from idle; cycle n=1 is the cycle right after the accepting edge.
    task automatic run_msg(input int sel, input logic [31:0] v, input int gap,
                           output int t_load, output int n_load, output int n_busy,
                           output int t_done, output int n_done, output logic [63:0] wd_load);
        logic ru, bz, dn;
        logic [63:0] wd;
        t_load = -1; n_load = 0; n_busy = 0; t_done = -1; n_done = 0; wd_load = '0;
        drive(sel, 1'b0, v);
        tick();
        drive(sel, 1'b1, v);
        tick();
        drive(sel, 1'b0, ~v);
        for (int n = 1; n <= gap + NC + 8; n++) begin
            sample(sel, ru, bz, dn, wd);
            if (ru) begin
                n_load++;
                if (t_load < 0) begin t_load = n; wd_load = wd; end
            end
            if (bz) n_busy++;
            if (dn) begin
                n_done++;
                if (t_done < 0) t_done = n;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic ru, bz, dn, rub, bzb, dnb;
        logic [63:0] wd, wdb;
        int pulses = 0, busy_cyc = 0;
        reset = 1'b1;
        drive(0, 1'b1, 32'h1234ABCD);
        drive(1, 1'b1, 32'h1234ABCD);
        repeat (3) tick();
        sample(0, ru, bz, dn, wd);
        checks++; if (wd !== 64'h0) begin failures++; $display("FAIL reset_write_data got=%h exp=0", wd); end
        checks++; if (ru !== 1'b0) begin failures++; $display("FAIL reset_read_uart got=%b exp=0", ru); end
        checks++; if (bz !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bz); end
        checks++; if (dn !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", dn); end
        reset = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            sample(0, ru, bz, dn, wd);
            sample(1, rub, bzb, dnb, wdb);
            if (ru || rub) pulses++;
            if (bz || bzb) busy_cyc++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL held_through_reset_pulses got=%0d exp=0", pulses); end
        checks++; if (busy_cyc !== 0) begin failures++; $display("FAIL held_through_reset_busy got=%0d exp=0", busy_cyc); end
        drive(0, 1'b0, 32'h0);
        drive(1, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_basic();
        int t_load, n_load, n_busy, t_done, n_done;
        logic [63:0] wd;
        logic [31:0] v = 32'h1234ABCD;
        run_msg(0, v, GAP_A, t_load, n_load, n_busy, t_done, n_done, wd);
        checks++; if (t_load !== 9) begin failures++; $display("FAIL basic_latency got=%0d exp=9", t_load); end
        checks++; if (n_load !== 1) begin failures++; $display("FAIL basic_pulses got=%0d exp=1", n_load); end
        checks++; if (wd !== model_word(v)) begin failures++; $display("FAIL basic_word got=%h exp=%h", wd, model_word(v)); end
        checks++; if (n_busy !== NC + 1 + GAP_A) begin failures++; $display("FAIL basic_busy_len got=%0d exp=%0d", n_busy, NC + 1 + GAP_A); end
        checks++; if (t_done !== NC + 2 + GAP_A) begin failures++; $display("FAIL basic_done_time got=%0d exp=%0d", t_done, NC + 2 + GAP_A); end
        checks++; if (n_done !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", n_done); end
        checks++; if (bus_a.write_data !== model_word(v)) begin failures++; $display("FAIL basic_word_stable got=%h exp=%h", bus_a.write_data, model_word(v)); end
    endtask

    task automatic test_held_level();
        logic ru, bz, dn;
        logic [63:0] wd;
        int pulses = 0, dones = 0;
        logic [31:0] v = $urandom;
        drive(0, 1'b0, v);
        tick();
        drive(0, 1'b1, v);
        for (int n = 0; n < 140; n++) begin
            tick();
            sample(0, ru, bz, dn, wd);
            if (ru) pulses++;
            if (dn) dones++;
            if (n == 99) drive(0, 1'b0, v);
        end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL held_level_pulses got=%0d exp=1", pulses); end
        checks++; if (dones !== 1) begin failures++; $display("FAIL held_level_done got=%0d exp=1", dones); end
    endtask

    task automatic test_hold_ignore();
        logic ru, bz, dn;
        logic [63:0] wd, wd_load;
        int n_load = 0, t_done = -1;
        int t2, n2, b2, d2, nd2;
        logic [31:0] v1 = $urandom;
        logic [31:0] v2 = ~v1;
        wd_load = '0;
        drive(0, 1'b0, v1);
        tick();
        drive(0, 1'b1, v1);
        tick();
        drive(0, 1'b0, v2);
        for (int n = 1; n <= 40; n++) begin
            sample(0, ru, bz, dn, wd);
            if (ru) begin n_load++; wd_load = wd; end
            if (dn && t_done < 0) t_done = n;
            case (n)
                4, 10, 16: drive(0, 1'b1, v2);
                3, 9, 15, 20: drive(0, 1'b0, v2);
                default: ;
            endcase
            tick();
        end
        checks++; if (n_load !== 1) begin failures++; $display("FAIL ignore_busy_pulses got=%0d exp=1", n_load); end
        checks++; if (wd_load !== model_word(v1)) begin failures++; $display("FAIL ignore_busy_word got=%h exp=%h", wd_load, model_word(v1)); end
        checks++; if (t_done !== NC + 2 + GAP_A) begin failures++; $display("FAIL ignore_busy_done got=%0d exp=%0d", t_done, NC + 2 + GAP_A); end
        run_msg(0, 32'h0, GAP_A, t2, n2, b2, d2, nd2, wd);
        checks++; if (n2 !== 1) begin failures++; $display("FAIL second_msg_pulses got=%0d exp=1", n2); end
        checks++; if (wd !== model_word(32'h0)) begin failures++; $display("FAIL second_msg_word got=%h exp=%h", wd, model_word(32'h0)); end
    endtask

    task automatic test_reset_mid();
        logic ru, bz, dn;
        logic [63:0] wd;
        int pulses = 0;
        int t_load, n_load, n_busy, t_done, n_done;
        logic [31:0] v = $urandom;
        drive(0, 1'b0, v);
        tick();
        drive(0, 1'b1, v);
        tick();
        drive(0, 1'b0, v);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sample(0, ru, bz, dn, wd);
        checks++; if (wd !== 64'h0) begin failures++; $display("FAIL midreset_write_data got=%h exp=0", wd); end
        checks++; if (bz !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", bz); end
        for (int n = 0; n < 30; n++) begin
            sample(0, ru, bz, dn, wd);
            if (ru) pulses++;
            tick();
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL midreset_pulses got=%0d exp=0", pulses); end
        v = $urandom;
        run_msg(0, v, GAP_A, t_load, n_load, n_busy, t_done, n_done, wd);
        checks++; if (t_load !== 9) begin failures++; $display("FAIL after_reset_latency got=%0d exp=9", t_load); end
        checks++; if (wd !== model_word(v)) begin failures++; $display("FAIL after_reset_word got=%h exp=%h", wd, model_word(v)); end
    endtask

    task automatic test_back_to_back();
        logic ru, bz, dn;
        logic [63:0] wd, wd2;
        int n_load = 0, t_second = -1, t_done = -1;
        logic [31:0] v1 = $urandom;
        logic [31:0] v2 = $urandom;
        wd2 = '0;
        // Edge arriving in the last HOLD cycle is dropped.
        drive(1, 1'b0, v1); tick(); drive(1, 1'b1, v1); tick(); drive(1, 1'b0, v1);
        for (int n = 1; n <= 40; n++) begin
            sample(1, ru, bz, dn, wd);
            if (ru) n_load++;
            if (n == 10) drive(1, 1'b1, v2);
            tick();
        end
        checks++; if (n_load !== 1) begin failures++; $display("FAIL edge_in_hold_pulses got=%0d exp=1", n_load); end
        // Edge in the done cycle (first IDLE cycle) is accepted.
        n_load = 0;
        drive(1, 1'b0, v1); tick(); drive(1, 1'b1, v1); tick(); drive(1, 1'b0, v1);
        for (int n = 1; n <= 40; n++) begin
            sample(1, ru, bz, dn, wd);
            if (ru) begin
                n_load++;
                if (n_load == 2) begin t_second = n; wd2 = wd; end
            end
            if (dn && t_done < 0) t_done = n;
            if (n == 11) drive(1, 1'b1, v2);
            if (n == 12) drive(1, 1'b0, v1);
            tick();
        end
        checks++; if (t_done !== NC + 2 + GAP_B) begin failures++; $display("FAIL b2b_done_time got=%0d exp=%0d", t_done, NC + 2 + GAP_B); end
        checks++; if (n_load !== 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", n_load); end
        checks++; if (t_second !== 20) begin failures++; $display("FAIL b2b_second_time got=%0d exp=20", t_second); end
        checks++; if (wd2 !== model_word(v2)) begin failures++; $display("FAIL b2b_second_word got=%h exp=%h", wd2, model_word(v2)); end
    endtask

    task automatic test_random_values();
        logic [31:0] vals[$];
        int t_load, n_load, n_busy, t_done, n_done;
        logic [63:0] wd;
        vals.push_back(32'hFFFFFFFF);
        vals.push_back(32'h9A9A9A9A);
        vals.push_back(32'h00000000);
        for (int i = 0; i < 12; i++) vals.push_back($urandom);
        foreach (vals[k]) begin
            run_msg(1, vals[k], GAP_B, t_load, n_load, n_busy, t_done, n_done, wd);
            checks++; if (t_load !== 9) begin failures++; $display("FAIL rnd_latency v=%h got=%0d exp=9", vals[k], t_load); end
            checks++; if (n_load !== 1) begin failures++; $display("FAIL rnd_pulses v=%h got=%0d exp=1", vals[k], n_load); end
            checks++; if (wd !== model_word(vals[k])) begin failures++; $display("FAIL rnd_word v=%h got=%h exp=%h", vals[k], wd, model_word(vals[k])); end
            checks++; if (n_busy !== NC + 1 + GAP_B) begin failures++; $display("FAIL rnd_busy_len v=%h got=%0d exp=%0d", vals[k], n_busy, NC + 1 + GAP_B); end
            checks++; if (t_done !== NC + 2 + GAP_B) begin failures++; $display("FAIL rnd_done_time v=%h got=%0d exp=%0d", vals[k], t_done, NC + 2 + GAP_B); end
            checks++; if (n_done !== 1) begin failures++; $display("FAIL rnd_done_count v=%h got=%0d exp=1", vals[k], n_done); end
        end
    endtask

    task automatic test_literals();
        int t_load, n_load, n_busy, t_done, n_done;
        logic [63:0] wd;
`ifdef UART_MSG_PACKER_CRLF_EN
        run_msg(1, 32'hFF00C0DE, GAP_B, t_load, n_load, n_busy, t_done, n_done, wd);
        checks++; if (wd !== 64'h0A0D454430433030) begin failures++; $display("FAIL crlf_word got=%h exp=0a0d454430433030", wd); end
`else
        run_msg(1, 32'h1234ABCD, GAP_B, t_load, n_load, n_busy, t_done, n_done, wd);
        checks++; if (wd !== 64'h4443424134333231) begin failures++; $display("FAIL lit_1234abcd got=%h exp=4443424134333231", wd); end
        run_msg(1, 32'hFFFFFFFF, GAP_B, t_load, n_load, n_busy, t_done, n_done, wd);
        checks++; if (wd !== 64'h4646464646464646) begin failures++; $display("FAIL lit_ffffffff got=%h exp=4646464646464646", wd); end
        run_msg(1, 32'h9A9A9A9A, GAP_B, t_load, n_load, n_busy, t_done, n_done, wd);
        checks++; if (wd !== 64'h4139413941394139) begin failures++; $display("FAIL lit_9a9a9a9a got=%h exp=4139413941394139", wd); end
`endif
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 32'h0);
        drive(1, 1'b0, 32'h0);
        test_reset();
        test_basic();
        test_held_level();
        test_hold_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random_values();
        test_literals();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
